// File: rtl/mmu_trace_buf.sv
// Passive MMU page-walk trace recorder: captures walk-state transitions whose PC falls
// inside a programmable window into a circular buffer drained over valid/ready.
module mmu_trace_buf #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 64,
  parameter int ST_W  = 4,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [XLEN-1:0]            pc,
  input  logic [ST_W-1:0]            state,
  input  logic [ST_W-1:0]            next_state,
  input  logic [XLEN-1:0]            addr,
  input  logic [XLEN-1:0]            pte,
  input  logic                       invalid,
  input  logic                       tlb_hit,
  input  logic                       cfg_en,
  input  logic                       cfg_wrap,
  input  logic [XLEN-1:0]            cfg_pc_lo,
  input  logic [XLEN-1:0]            cfg_pc_hi,
  input  logic                       clr,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [XLEN-1:0]            rd_pc,
  output logic [XLEN-1:0]            rd_addr,
  output logic [XLEN-1:0]            rd_pte,
  output logic [ST_W-1:0]            rd_state,
  output logic [ST_W-1:0]            rd_next,
  output logic [1:0]                 rd_flags,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic [CNT_W-1:0]           hit_cnt,
  output logic [CNT_W-1:0]           fault_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] addr_mem [DEPTH];
  logic [XLEN-1:0] pte_mem  [DEPTH];
  logic [ST_W-1:0] st_mem   [DEPTH];
  logic [ST_W-1:0] nx_mem   [DEPTH];
  logic [1:0]      flg_mem  [DEPTH];

  logic [AW-1:0] wr, rd;
  logic [LW-1:0] level_q;
  logic          ev, pop, push, drop, adv_rd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  assign level    = level_q;
  assign full     = (level_q == LW'(DEPTH));
  assign rd_valid = (level_q != '0);

  always_comb begin
    ev     = cfg_en && (pc >= cfg_pc_lo) && (pc <= cfg_pc_hi) && (state != next_state);
    pop    = rd_valid && rd_ready;
    // When full without a pop, wrap mode still writes by retiring the oldest entry.
    push   = ev && (!full || pop || cfg_wrap);
    drop   = ev && full && !pop;
    adv_rd = pop || (drop && cfg_wrap);
  end

  // Control state: pointers, occupancy and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr        <= '0;
      rd        <= '0;
      level_q   <= '0;
      hit_cnt   <= '0;
      fault_cnt <= '0;
      drop_cnt  <= '0;
    end else if (clr) begin
      wr        <= '0;
      rd        <= '0;
      level_q   <= '0;
      hit_cnt   <= '0;
      fault_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push)   wr <= wr + AW'(1);
      if (adv_rd) rd <= rd + AW'(1);
      if (push && !adv_rd)      level_q <= level_q + LW'(1);
      else if (adv_rd && !push) level_q <= level_q - LW'(1);
      hit_cnt   <= sat_inc(hit_cnt,   ev && tlb_hit);
      fault_cnt <= sat_inc(fault_cnt, ev && invalid);
      drop_cnt  <= sat_inc(drop_cnt,  drop);
    end
  end

  // Entry storage is data only and is never reset
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      pc_mem[wr]   <= pc;
      addr_mem[wr] <= addr;
      pte_mem[wr]  <= pte;
      st_mem[wr]   <= state;
      nx_mem[wr]   <= next_state;
      flg_mem[wr]  <= {invalid, tlb_hit};
    end
  end

  assign rd_pc    = pc_mem[rd];
  assign rd_addr  = addr_mem[rd];
  assign rd_pte   = pte_mem[rd];
  assign rd_state = st_mem[rd];
  assign rd_next  = nx_mem[rd];
  assign rd_flags = flg_mem[rd];

endmodule

// File: tb/tb_mmu_trace_buf.sv
// Directed bench for mmu_trace_buf with a queue-based reference model checked every cycle.
module tb_mmu_trace_buf;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;
  localparam int ST_W  = 4;
  localparam int CNT_W = 3;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic            clk = 0;
  logic            rst_n = 0;
  logic [XLEN-1:0] pc = '0, addr = '0, pte = '0, cfg_pc_lo = '0, cfg_pc_hi = '0;
  logic [ST_W-1:0] state = '0, next_state = '0;
  logic            invalid = 0, tlb_hit = 0, cfg_en = 0, cfg_wrap = 0, clr = 0, rd_ready = 0;
  logic            rd_valid, full;
  logic [XLEN-1:0] rd_pc, rd_addr, rd_pte;
  logic [ST_W-1:0] rd_state, rd_next;
  logic [1:0]      rd_flags;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0] hit_cnt, fault_cnt, drop_cnt;

  int errors = 0;
  int checks = 0;

  mmu_trace_buf #(.DEPTH(DEPTH), .XLEN(XLEN), .ST_W(ST_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .state(state), .next_state(next_state),
    .addr(addr), .pte(pte), .invalid(invalid), .tlb_hit(tlb_hit), .cfg_en(cfg_en),
    .cfg_wrap(cfg_wrap), .cfg_pc_lo(cfg_pc_lo), .cfg_pc_hi(cfg_pc_hi), .clr(clr),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_addr(rd_addr),
    .rd_pte(rd_pte), .rd_state(rd_state), .rd_next(rd_next), .rd_flags(rd_flags),
    .level(level), .full(full), .hit_cnt(hit_cnt), .fault_cnt(fault_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of kept events plus plain integer counters
  typedef struct packed {
    logic [XLEN-1:0] pc, addr, pte;
    logic [ST_W-1:0] st, nx;
    logic [1:0]      flg;
  } ent_t;

  ent_t m_q[$];
  int   m_hit = 0, m_fault = 0, m_drop = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      m_q.delete();
      m_hit = 0; m_fault = 0; m_drop = 0;
    end else begin
      bit   m_ev;
      ent_t e;
      m_ev = cfg_en && pc >= cfg_pc_lo && pc <= cfg_pc_hi && state != next_state;
      if (rd_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (m_ev) begin
        e = '{pc: pc, addr: addr, pte: pte, st: state, nx: next_state, flg: {invalid, tlb_hit}};
        if (tlb_hit) m_hit   = (m_hit   < MAXC) ? m_hit + 1   : MAXC;
        if (invalid) m_fault = (m_fault < MAXC) ? m_fault + 1 : MAXC;
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else begin
          m_drop = (m_drop < MAXC) ? m_drop + 1 : MAXC;
          if (cfg_wrap) begin
            void'(m_q.pop_front());
            m_q.push_back(e);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("level",     64'(level),     64'(m_q.size()));
      check("full",      64'(full),      64'(m_q.size() == DEPTH));
      check("rd_valid",  64'(rd_valid),  64'(m_q.size() != 0));
      check("hit_cnt",   64'(hit_cnt),   64'(m_hit));
      check("fault_cnt", 64'(fault_cnt), 64'(m_fault));
      check("drop_cnt",  64'(drop_cnt),  64'(m_drop));
      if (m_q.size() != 0) begin
        check("rd_pc",    rd_pc,           m_q[0].pc);
        check("rd_addr",  rd_addr,         m_q[0].addr);
        check("rd_pte",   rd_pte,          m_q[0].pte);
        check("rd_state", 64'(rd_state),   64'(m_q[0].st));
        check("rd_next",  64'(rd_next),    64'(m_q[0].nx));
        check("rd_flags", 64'(rd_flags),   64'(m_q[0].flg));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    state = 4'd0; next_state = 4'd0; invalid = 0; tlb_hit = 0; rd_ready = 0; clr = 0;
  endtask

  task automatic evt(input logic [63:0] p, input logic [3:0] s, input logic [3:0] n,
                     input logic [63:0] a, input logic inv, input logic hit);
    pc = p; state = s; next_state = n; addr = a; pte = a ^ 64'hFFFF_0000_0000_0000;
    invalid = inv; tlb_hit = hit;
    step();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      rd_ready = 1;
      step();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_level", 64'(level), 64'd0);
    check("reset_valid", 64'(rd_valid), 64'd0);
    check("reset_full",  64'(full), 64'd0);
    check("reset_hit",   64'(hit_cnt), 64'd0);
    check("reset_drop",  64'(drop_cnt), 64'd0);
    rst_n = 1;
    cfg_en = 1; cfg_wrap = 0; cfg_pc_lo = 64'h1000; cfg_pc_hi = 64'h1FFF;
    step();

    // Basic capture: three transitions and one steady cycle
    evt(64'h1004, 4'd1, 4'd2, 64'hA1, 0, 0);
    evt(64'h1004, 4'd2, 4'd3, 64'hA2, 0, 1);
    evt(64'h1004, 4'd3, 4'd4, 64'hA3, 1, 0);
    evt(64'h1004, 4'd5, 4'd5, 64'hA4, 0, 0);
    check("basic_level", 64'(level), 64'd3);
    check("basic_head",  rd_addr, 64'hA1);
    check("basic_state", 64'(rd_state), 64'd1);
    drain(3);
    check("basic_empty", 64'(rd_valid), 64'd0);

    // Window edges and an empty window
    evt(64'h0FFC, 4'd1, 4'd2, 64'hB1, 0, 0);
    evt(64'h2000, 4'd1, 4'd2, 64'hB2, 0, 0);
    check("win_outside", 64'(level), 64'd0);
    evt(64'h1FFF, 4'd1, 4'd2, 64'hB3, 0, 0);
    check("win_edge", 64'(level), 64'd1);
    drain(1);
    cfg_pc_lo = 64'h3000; cfg_pc_hi = 64'h2000;
    evt(64'h2800, 4'd1, 4'd2, 64'hB4, 0, 0);
    check("win_empty", 64'(level), 64'd0);
    cfg_pc_lo = 64'h1000; cfg_pc_hi = 64'h1FFF;

    // Stop mode: six events into four entries
    for (int i = 1; i <= 6; i++) evt(64'h1100, 4'd2, 4'd3, 64'(i), 0, 0);
    check("stop_level", 64'(level), 64'd4);
    check("stop_drop",  64'(drop_cnt), 64'd2);
    check("stop_head",  rd_addr, 64'd1);
    check("stop_full",  64'(full), 64'd1);

    // Full with simultaneous push and pop
    rd_ready = 1;
    evt(64'h1100, 4'd2, 4'd3, 64'd7, 0, 0);
    check("pp_level", 64'(level), 64'd4);
    check("pp_drop",  64'(drop_cnt), 64'd2);
    check("pp_head",  rd_addr, 64'd2);
    drain(4);

    // Wrap mode: oldest two are overwritten
    clr = 1; step();
    cfg_wrap = 1;
    for (int i = 1; i <= 6; i++) evt(64'h1200, 4'd4, 4'd5, 64'(10 + i), 0, 0);
    check("wrap_level", 64'(level), 64'd4);
    check("wrap_drop",  64'(drop_cnt), 64'd2);
    for (int i = 0; i < 4; i++) begin
      check("wrap_order", rd_addr, 64'(13 + i));
      rd_ready = 1;
      step();
    end

    // Counters, saturation, clear with a coincident event
    clr = 1; step();
    cfg_wrap = 0;
    for (int i = 0; i < 5; i++) evt(64'h1300, 4'd1, 4'd6, 64'(20 + i), 0, 1);
    for (int i = 0; i < 2; i++) evt(64'h1300, 4'd1, 4'd7, 64'(30 + i), 1, 0);
    check("cnt_hit",   64'(hit_cnt), 64'd5);
    check("cnt_fault", 64'(fault_cnt), 64'd2);
    for (int i = 0; i < 4; i++) evt(64'h1300, 4'd1, 4'd6, 64'(40 + i), 0, 1);
    check("cnt_sat", 64'(hit_cnt), 64'd7);
    clr = 1;
    evt(64'h1300, 4'd1, 4'd6, 64'h55, 1, 1);
    check("clr_level", 64'(level), 64'd0);
    check("clr_hit",   64'(hit_cnt), 64'd0);
    check("clr_fault", 64'(fault_cnt), 64'd0);
    check("clr_drop",  64'(drop_cnt), 64'd0);

    // Asynchronous reset in the middle of a stream
    evt(64'h1400, 4'd2, 4'd8, 64'h61, 0, 1);
    evt(64'h1400, 4'd2, 4'd9, 64'h62, 1, 0);
    #2 rst_n = 0;
    #1;
    check("arst_level", 64'(level), 64'd0);
    check("arst_valid", 64'(rd_valid), 64'd0);
    check("arst_hit",   64'(hit_cnt), 64'd0);
    check("arst_fault", 64'(fault_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    evt(64'h1400, 4'd3, 4'd4, 64'h63, 0, 0);
    check("post_arst_level", 64'(level), 64'd1);
    drain(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmu_trace_buf.md
# mmu_trace_buf

Parametrised MMU trace recorder. It samples the page-walk state machine's per-cycle status and keeps state-transition events that fall inside a programmable PC window. Kept events go into a DEPTH-entry circular buffer that a debug reader drains over a valid/ready port. It also keeps saturating hit, fault and drop counters, and sits beside the MMU as a passive observer with no influence on MMU behaviour.

## Interface
- DEPTH, 16: buffer entries; power of two, at least 2.
- XLEN, 64: width of pc, addr and pte.
- ST_W, 4: width of state and next_state.
- CNT_W, 32: width of each statistics counter.
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- pc  in  XLEN  PC of the instruction the MMU is serving.
- state / next_state  in  ST_W  current and next walk state.
- addr / pte  in  XLEN  virtual address and current PTE.
- invalid  in  1  fault/invalid PTE flag.
- tlb_hit  in  1  TLB hit flag.
- cfg_en  in  1  capture enable.
- cfg_wrap  in  1  0 = stop when full; 1 = overwrite oldest entry.
- cfg_pc_lo / cfg_pc_hi  in  XLEN  inclusive PC window.
- clr  in  1  synchronous clear of buffer and counters.
- rd_ready  in  1  reader accepts the head entry.
- rd_valid  out  1  buffer non-empty.
- rd_pc, rd_addr, rd_pte  out  XLEN  head entry fields.
- rd_state, rd_next  out  ST_W  head entry states.
- rd_flags  out  2  {invalid, tlb_hit} of the head entry.
- level  out  $clog2(DEPTH)+1  entries held.
- full  out  1  level == DEPTH.
- hit_cnt, fault_cnt, drop_cnt  out  CNT_W  statistics counters.

## Operation
- Event condition `ev`: cfg_en && cfg_pc_lo <= pc <= cfg_pc_hi && state != next_state. All comparisons are unsigned.
  - If cfg_pc_lo > cfg_pc_hi, the window is empty and nothing is captured.
- Storage: each entry holds {pc, state, next_state, addr, pte, invalid, tlb_hit}.
  - Write pointer wr, read pointer rd, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Push: `ev` writes an entry at wr and advances wr.
- Pop: rd_valid && rd_ready advances rd.
- Head data: rd_* fields reflect the entry at rd (first-word-fall-through).
  - rd_* contents are don't-care while rd_valid = 0.
- Full, with `ev` and no pop:
  - cfg_wrap = 0: the event is discarded; buffer is unchanged; drop_cnt increments.
  - cfg_wrap = 1: the entry at wr overwrites the oldest; wr and rd both advance; level stays DEPTH; drop_cnt increments.
- Full, with `ev` and pop in the same cycle: both happen, level is unchanged, no drop.
- Empty, with `ev` and rd_ready: no pop occurs, because rd_valid = 0; the push happens.
- Counters:
  - On every `ev`, hit_cnt += tlb_hit and fault_cnt += invalid, whether or not the entry is stored.
  - All counters saturate at 2^CNT_W-1.
- clr:
  - Zeroes wr, rd, level and all counters.
  - Takes priority over any push or pop in the same cycle.
- cfg_* changes take effect on the next sampled edge; stored entries are not altered.

## Timing
- Reset values: level = 0, full = 0, rd_valid = 0, all counters 0, wr = rd = 0.
  - Buffer RAM contents are not reset.
- All inputs are sampled on the rising edge of clk.
- An event sampled at edge N is visible on rd_* at N+1, with rd_valid = 1 if the buffer was empty.
- Pop at edge N presents the next entry at N+1.
- level, full and the counters are registered and update at the same edge as the push, pop, drop or clr that changes them.
- Throughput is one push and one pop per cycle, with no bubbles.
- An asynchronous reset mid-operation discards all entries and counts immediately.

## Test plan
- Basic capture: cfg_en = 1, window 0x1000..0x1FFF, three transitions at pc 0x1004, plus one cycle with state == next_state -> level = 3, entries in order; popping all three gives rd_valid = 0.
- Window filter: event at pc 0x0FFC and another at 0x2000 -> nothing captured; event at pc 0x1FFF -> captured; with lo > hi -> nothing captured.
- Stop mode: DEPTH = 4, cfg_wrap = 0, six events with no reads -> level = 4, drop_cnt = 2, head is event #1.
- Wrap mode: DEPTH = 4, cfg_wrap = 1, six events -> level = 4, drop_cnt = 2, read order is events #3..#6.
- Full with simultaneous push and pop: level stays 4, drop_cnt unchanged, popped entry is the oldest.
- Counters and clear: five events with tlb_hit = 1 and two with invalid = 1 -> hit_cnt = 5, fault_cnt = 2. Then clr together with `ev` -> everything zero, event not stored. Then rst_n pulsed mid-stream -> all outputs at reset values.
